keypad_entry: RTL and testbench
===============================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per column drive period (1 ms at 50 MHz).
REQ-002 Parameter DEBOUNCE_CNT, default 4: consecutive identical full scans needed to accept a press or a release.
REQ-003 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 rst_neg  input  1  reset; synchronous, active-low.
REQ-005 row_neg  input  4  keypad row sense, active-low, externally pulled up; asynchronous.
REQ-006 col_neg  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 amount  output  32  unsigned binary value of the digits entered so far.
REQ-008 digit_count  output  4  number of digits currently held, 0..9.
REQ-009 amount_valid  output  1  one-cycle pulse; amount is the committed value in that cycle.
REQ-010 key_code  output  4  code of the last accepted key.
REQ-011 key_strobe  output  1  one-cycle pulse per accepted key press.

Function
REQ-012 row_neg shall pass through a 2-flop synchronizer before any use.
REQ-013 The scanner shall drive columns 0,1,2,3 cyclically, each low for SCAN_DIV cycles; rows shall be sampled in the last cycle of each column period; 4 column periods form one full scan.
REQ-014 Key map (row,col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D. key_code = digit value for 0-9, A=0xA, B=0xB, C=0xC, D=0xD, *=0xE, #=0xF.
REQ-015 A full scan shall yield "key K" only if exactly one row/column intersection reads low; zero or more than one shall yield "no key" (ghosting rejection).
REQ-016 FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
REQ-017 IDLE -> DEBOUNCE on a scan yielding key K; DEBOUNCE counts consecutive scans yielding the same K; a scan yielding a different key or no key returns to IDLE with count cleared.
REQ-018 When the count reaches DEBOUNCE_CNT: key_strobe pulses for one cycle, key_code takes K in that cycle, the key action is applied, and the FSM enters HELD.
REQ-019 HELD -> RELEASE on a no-key scan; RELEASE -> IDLE after DEBOUNCE_CNT consecutive no-key scans; any key scan in RELEASE returns to HELD; no repeat strobe while HELD or RELEASE.
REQ-020 Digit action: if digit_count < 9, amount <= amount*10 + d (shift-and-add, (a<<3)+(a<<1)+d) and digit_count increments; at digit_count = 9 the digit is ignored.
REQ-021 Digit 0 with digit_count = 0 shall be ignored (no leading zeros).
REQ-022 '*' (backspace): if digit_count > 0, amount <= amount/10 truncated and digit_count decrements; at 0 there is no change; a multi-cycle divider is permitted if it completes within one column period.
REQ-023 '#' (enter): if digit_count > 0, amount_valid pulses for one cycle with amount holding the entered value, and amount and digit_count clear in the following cycle; at digit_count = 0 there is no pulse.
REQ-024 'D' (clear) shall zero amount and digit_count without pulsing amount_valid; A, B and C shall strobe but change nothing else.
REQ-025 amount updates shall be visible the cycle after key_strobe, except for the enter commit (REQ-023).

Reset
REQ-026 While rst_neg = 0 at a clock edge: col_neg = 4'b1110, amount = 0, digit_count = 0, amount_valid = 0, key_strobe = 0, key_code = 0, FSM = IDLE, and all divider, debounce and column counters = 0.
REQ-027 Reset asserted mid-entry or mid-debounce shall discard all partial state; a key held through reset shall be re-debounced from IDLE.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=2)
REQ-028 Press/release 1, 2, 3, # -> key_strobe x4, amount 1 -> 12 -> 123; amount_valid pulses with amount = 123; amount = 0 and digit_count = 0 on the next cycle.
REQ-029 Key 5 low for one scan only, then released -> no key_strobe, amount unchanged; key 5 held for 6 scans -> exactly one strobe, amount = 5.
REQ-030 Key 9 entered ten times -> amount = 999999999, digit_count = 9; the tenth press strobes but amount is unchanged.
REQ-031 Keys 4, 5, *, *, * -> amount 45 -> 4 -> 0, digit_count 2 -> 1 -> 0 -> 0; a following 0 then # -> no amount_valid pulse.
REQ-032 Keys 1 and 2 held together -> no strobe; release 2 -> after 2 scans, one strobe with key_code = 1.
REQ-033 Enter 7, 8, then assert rst_neg = 0 for one cycle -> amount = 0, digit_count = 0, col_neg = 4'b1110 on the following edge.

Source files
------------

// File: rtl/keypad_entry.sv
// Purpose: scans a 4x4 keypad, debounces single-key presses and builds an unsigned decimal amount.
// Latency: a key strobes DEBOUNCE_CNT full scans after it is first seen; amount follows one cycle after key_strobe.
// Backpressure: none; key_strobe and amount_valid are one-cycle pulses that must be taken when they occur.
module keypad_entry #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_neg,
    input  logic [3:0]  row_neg,
    output logic [3:0]  col_neg,
    output logic [31:0] amount,
    output logic [3:0]  digit_count,
    output logic        amount_valid,
    output logic [3:0]  key_code,
    output logic        key_strobe
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  row_meta, row_sync;
    logic [31:0] div_cnt;
    logic [1:0]  col_idx;
    logic [1:0]  acc_hits, col_hits;
    logic [3:0]  acc_key, col_key;
    logic [2:0]  tot_hits;
    logic        sample_now, scan_done, scan_key_vld;
    logic [3:0]  scan_key;
    logic [7:0]  deb_cnt, deb_cnt_nxt;
    logic [3:0]  cur_key, cur_key_nxt;
    logic        accept;

    // Key legend by (row, column).
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Two-flop synchronizer for the asynchronous row lines (idle rows read high).
    always_ff @(posedge clk) begin
        if (!rst_neg) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_neg;
            row_sync <= row_meta;
        end
    end

    assign sample_now = (div_cnt == 32'(SCAN_DIV - 1));
    assign scan_done  = sample_now && (col_idx == 2'd3);

    // Count low rows in the driven column (saturating at 2, enough to detect ghosting).
    always_comb begin
        col_hits = 2'd0;
        col_key  = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
                col_key = key_map(2'(r), col_idx);
            end
        end
    end

    assign tot_hits     = {1'b0, acc_hits} + {1'b0, col_hits};
    assign scan_key_vld = scan_done && (tot_hits == 3'd1);
    assign scan_key     = (acc_hits == 2'd1) ? acc_key : col_key;

    // Column divider/rotation and per-scan accumulation of intersections that read low.
    always_ff @(posedge clk) begin
        if (!rst_neg) begin
            div_cnt  <= '0;
            col_idx  <= 2'd0;
            col_neg  <= 4'b1110;
            acc_hits <= 2'd0;
            acc_key  <= 4'h0;
        end else if (sample_now) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
            col_neg <= ~(4'b0001 << (col_idx + 2'd1));
            if (col_idx == 2'd3) begin
                acc_hits <= 2'd0;
                acc_key  <= 4'h0;
            end else begin
                acc_hits <= (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
                if (col_hits != 2'd0) acc_key <= col_key;
            end
        end else begin
            div_cnt <= div_cnt + 32'd1;
        end
    end

    // Debounce FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_neg) begin
            state   <= IDLE;
            deb_cnt <= 8'd0;
            cur_key <= 4'h0;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_cnt_nxt;
            cur_key <= cur_key_nxt;
        end
    end

    // Debounce FSM next state; only evaluated once per completed full scan.
    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        cur_key_nxt = cur_key;
        accept      = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: if (scan_key_vld) begin
                    cur_key_nxt = scan_key;
                    if (8'd1 >= 8'(DEBOUNCE_CNT)) begin
                        accept      = 1'b1;
                        state_nxt   = HELD;
                        deb_cnt_nxt = 8'd0;
                    end else begin
                        state_nxt   = DEBOUNCE;
                        deb_cnt_nxt = 8'd1;
                    end
                end
                DEBOUNCE: if (scan_key_vld && scan_key == cur_key) begin
                    if (deb_cnt + 8'd1 >= 8'(DEBOUNCE_CNT)) begin
                        accept      = 1'b1;
                        state_nxt   = HELD;
                        deb_cnt_nxt = 8'd0;
                    end else begin
                        deb_cnt_nxt = deb_cnt + 8'd1;
                    end
                end else begin
                    state_nxt   = IDLE;
                    deb_cnt_nxt = 8'd0;
                end
                HELD: if (!scan_key_vld) begin
                    if (8'd1 >= 8'(DEBOUNCE_CNT)) begin
                        state_nxt   = IDLE;
                        deb_cnt_nxt = 8'd0;
                    end else begin
                        state_nxt   = RELEASE;
                        deb_cnt_nxt = 8'd1;
                    end
                end
                default: if (scan_key_vld) begin
                    state_nxt   = HELD;
                    deb_cnt_nxt = 8'd0;
                end else if (deb_cnt + 8'd1 >= 8'(DEBOUNCE_CNT)) begin
                    state_nxt   = IDLE;
                    deb_cnt_nxt = 8'd0;
                end else begin
                    deb_cnt_nxt = deb_cnt + 8'd1;
                end
            endcase
        end
    end

    // Register the accepted key as a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (!rst_neg) begin
            key_strobe <= 1'b0;
            key_code   <= 4'h0;
        end else begin
            key_strobe <= accept;
            if (accept) key_code <= scan_key;
        end
    end

    // Apply the key action in the strobe cycle; an enter commit clears one cycle after its pulse.
    always_ff @(posedge clk) begin
        if (!rst_neg) begin
            amount       <= 32'd0;
            digit_count  <= 4'd0;
            amount_valid <= 1'b0;
        end else begin
            amount_valid <= 1'b0;
            if (amount_valid) begin
                amount      <= 32'd0;
                digit_count <= 4'd0;
            end else if (key_strobe) begin
                case (key_code)
                    4'hA, 4'hB, 4'hC: ;
                    4'hD: begin
                        amount      <= 32'd0;
                        digit_count <= 4'd0;
                    end
                    4'hE: if (digit_count != 4'd0) begin
                        amount      <= amount / 32'd10;
                        digit_count <= digit_count - 4'd1;
                    end
                    4'hF: if (digit_count != 4'd0) amount_valid <= 1'b1;
                    default: if (digit_count < 4'd9 && !(key_code == 4'h0 && digit_count == 4'd0)) begin
                        amount      <= (amount << 3) + (amount << 1) + {28'd0, key_code};
                        digit_count <= digit_count + 4'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Purpose: drives a simulated 4x4 keypad into keypad_entry and checks strobes and amount against a decimal model.
// Latency: waits whole scans per press/release, so debounce timing never needs to be predicted cycle-exactly.
// Backpressure: none; DUT pulses are counted by a monitor sampling on the falling edge.
module tb_keypad_entry;

    localparam int SD   = 4;
    localparam int DC   = 2;
    localparam int SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_neg;
    logic [3:0]  row_neg;
    logic [3:0]  col_neg;
    logic [31:0] amount;
    logic [3:0]  digit_count;
    logic        amount_valid;
    logic [3:0]  key_code;
    logic        key_strobe;

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk(clk), .rst_neg(rst_neg), .row_neg(row_neg), .col_neg(col_neg),
        .amount(amount), .digit_count(digit_count), .amount_valid(amount_valid),
        .key_code(key_code), .key_strobe(key_strobe)
    );

    always #5 clk = ~clk;

    // Physical keypad: position r*4+c shorts row r to column c.
    logic [15:0] keys;
    logic [3:0]  pos_code [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                   4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    always_comb begin
        row_neg = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_neg[c]) row_neg[r] = 1'b0;
    end

    int checks = 0;
    int failures = 0;

    // Monitor of DUT pulses.
    int          n_strobe = 0, n_valid = 0, bad_col = 0;
    longint      last_commit = 0, post_amt = -1, post_dc = -1;
    logic        chk_next = 1'b0;
    always @(negedge clk) begin
        if (key_strobe) n_strobe++;
        if (amount_valid) begin
            n_valid++;
            last_commit = amount;
            chk_next = 1'b1;
        end else if (chk_next) begin
            post_amt = amount;
            post_dc  = digit_count;
            chk_next = 1'b0;
        end
        if ($countones(~col_neg) != 1) bad_col++;
    end

    // Reference model in plain decimal arithmetic.
    longint m_amt = 0, m_dc = 0, m_commit = 0;
    int     m_strobes = 0, m_valid = 0;

    task automatic model_apply(input logic [3:0] k);
        m_strobes++;
        if (k <= 4'd9) begin
            if (m_dc < 9 && !(k == 4'd0 && m_dc == 0)) begin
                m_amt = m_amt * 10 + longint'(k);
                m_dc++;
            end
        end else if (k == 4'hE) begin
            if (m_dc > 0) begin m_amt = m_amt / 10; m_dc--; end
        end else if (k == 4'hF) begin
            if (m_dc > 0) begin m_valid++; m_commit = m_amt; m_amt = 0; m_dc = 0; end
        end else if (k == 4'hD) begin
            m_amt = 0; m_dc = 0;
        end
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pos_of(input logic [3:0] k);
        int p = 0;
        for (int i = 0; i < 16; i++) if (pos_code[i] == k) p = i;
        return p;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".strobes"}, n_strobe, m_strobes);
        chk({tag, ".amount"}, amount, m_amt);
        chk({tag, ".digits"}, digit_count, m_dc);
        chk({tag, ".valids"}, n_valid, m_valid);
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int rel);
        logic will_commit;
        will_commit = (k == 4'hF) && (m_dc > 0);
        keys = '0;
        keys[pos_of(k)] = 1'b1;
        repeat (hold * SCAN) @(negedge clk);
        keys = '0;
        repeat (rel * SCAN) @(negedge clk);
        model_apply(k);
        check_state("press");
        chk("press.key_code", key_code, k);
        if (will_commit) begin
            chk("enter.commit", last_commit, m_commit);
            chk("enter.post_amount", post_amt, 0);
            chk("enter.post_digits", post_dc, 0);
        end
    endtask

    task automatic do_reset();
        rst_neg = 1'b0;
        @(negedge clk);
        chk("reset.col_neg", col_neg, 4'b1110);
        chk("reset.amount", amount, 0);
        chk("reset.digits", digit_count, 0);
        chk("reset.key_code", key_code, 0);
        chk("reset.strobe", key_strobe, 0);
        chk("reset.valid", amount_valid, 0);
        rst_neg = 1'b1;
        m_amt = 0;
        m_dc = 0;
    endtask

    initial begin
        logic [3:0] k;
        keys = '0;
        rst_neg = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        repeat (2) @(negedge clk);

        // Basic entry and commit.
        press(4'h1, 4, 4);
        press(4'h2, 4, 4);
        press(4'h3, 4, 4);
        chk("entry.123", amount, 123);
        press(4'hF, 4, 4);
        chk("entry.commit123", last_commit, 123);

        // A one-scan blip is rejected; a long hold strobes once.
        keys = '0;
        keys[pos_of(4'h5)] = 1'b1;
        repeat (SCAN) @(negedge clk);
        keys = '0;
        repeat (5 * SCAN) @(negedge clk);
        check_state("blip");
        press(4'h5, 6, 4);
        chk("hold.amount5", amount, 5);

        // Ten nines saturate at nine digits.
        press(4'hD, 4, 4);
        for (int i = 0; i < 10; i++) press(4'h9, 4, 4);
        chk("nines.amount", amount, 999999999);
        chk("nines.digits", digit_count, 9);

        // Backspace down to zero, then leading zero and empty enter.
        press(4'hD, 4, 4);
        press(4'h4, 4, 4);
        press(4'h5, 4, 4);
        press(4'hE, 4, 4);
        chk("bs.amount4", amount, 4);
        press(4'hE, 4, 4);
        press(4'hE, 4, 4);
        press(4'h0, 4, 4);
        press(4'hF, 4, 4);
        chk("bs.no_valid", n_valid, 1);

        // Two keys together are ghosted; releasing one lets the other through.
        keys = '0;
        keys[pos_of(4'h1)] = 1'b1;
        keys[pos_of(4'h2)] = 1'b1;
        repeat (4 * SCAN) @(negedge clk);
        chk("ghost.strobes", n_strobe, m_strobes);
        keys[pos_of(4'h2)] = 1'b0;
        repeat (4 * SCAN) @(negedge clk);
        keys = '0;
        repeat (4 * SCAN) @(negedge clk);
        model_apply(4'h1);
        check_state("ghost_release");
        chk("ghost.key_code", key_code, 1);

        // Reset in the middle of an entry discards it.
        press(4'h7, 4, 4);
        press(4'h8, 4, 4);
        @(negedge clk);
        do_reset();

        // A key held through reset is debounced again from scratch.
        keys = '0;
        keys[pos_of(4'h3)] = 1'b1;
        repeat (4 * SCAN) @(negedge clk);
        model_apply(4'h3);
        check_state("held_pre");
        do_reset();
        repeat (4 * SCAN) @(negedge clk);
        keys = '0;
        repeat (4 * SCAN) @(negedge clk);
        model_apply(4'h3);
        check_state("held_post");

        // Random key sequence, biased toward digits.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) != 0) k = 4'($urandom_range(0, 9));
            else k = 4'($urandom_range(0, 15));
            press(k, $urandom_range(4, 6), $urandom_range(4, 5));
        end

        chk("col_neg.one_low", bad_col, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
